corrector_hamming: RTL and testbench
====================================

# corrector_hamming

Registered SECDED (8,4) correction stage that sits directly downstream of the syndrome calculator. It accepts the received 8-bit word together with its 4-bit syndrome and classifies the result as no error, single error (corrected) or double error (detected only). It returns the 4 data bits and maintains saturating error counters. Transfers use valid/ready handshakes on both sides through a 2-stage pipeline with full backpressure.

## Interface
- `CNT_W`, default 8, width of each saturating error counter.

- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `palabra_rx`/`sindrome` valid.
- `in_ready`  out  1  stage can accept an input this cycle.
- `palabra_rx`  in  8  received word; bit order 7..0 = g0,w3,w2,w1,p2,w0,p1,p0.
- `sindrome`  in  4  {g1,c2,c1,c0} from the syndrome stage; g1 = XOR of bits 6..0 and excludes g0.
- `clr_cnt`  in  1  synchronous clear of both counters.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `dato`  out  4  {w3,w2,w1,w0} after correction.
- `tipo_error`  out  2  00 none, 01 single corrected, 10 double detected; 11 never produced.
- `pos_error`  out  3  corrected bit index 0..7; 0 unless `tipo_error`=01.
- `cnt_simple`  out  CNT_W  count of single-error results delivered.
- `cnt_doble`  out  CNT_W  count of double-error results delivered.

## Operation
- Definitions: s = `sindrome[2:0]`; pe = `sindrome[3]` ^ `palabra_rx[7]`.
- Classification:
  - s=0, pe=0: none.
  - pe=1, s=0: single error in g0; `pos_error`=7; data unchanged.
  - pe=1, s≠0: single error at bit s−1; flip that bit before extraction.
  - pe=0, s≠0: double error; `dato` = uncorrected {bit6,bit5,bit4,bit2}; `pos_error`=0.
- Stage 1 (S1) registers `palabra_rx`, `sindrome` and a valid bit.
- Stage 2 (S2) registers the classification, corrected `dato`, `pos_error` and a valid bit. `out_valid` is the S2 valid bit.
- Advance rules:
  - s2_load = S1 valid & (~S2 valid | `out_ready`).
  - `in_ready` = ~S1 valid | s2_load (combinational; no dependency on `in_valid`).
- Counters:
  - `cnt_simple` increments on an output handshake (`out_valid` & `out_ready`) with `tipo_error`=01.
  - `cnt_doble` increments on an output handshake with `tipo_error`=10.
  - Both saturate at 2^CNT_W−1 and never wrap.
  - `clr_cnt` zeroes both counters next edge and takes priority over a simultaneous increment.

## Timing
- Reset (async assert, any cycle including mid-transfer) drops all in-flight data. Reset values:
  - S1/S2 valid = 0, so `out_valid`=0 and `in_ready`=1.
  - `dato`=0, `tipo_error`=00, `pos_error`=0.
  - `cnt_simple`=0, `cnt_doble`=0.
- Latency: input accepted at edge N appears with `out_valid`=1 after edge N+1. That is 2 cycles from presentation with `out_ready` held high.
- Throughput: 1 result/cycle with `out_ready`=1 continuously.
- Stall: with `out_ready`=0, S2 holds `dato`/`tipo_error`/`pos_error` stable and S1 fills. `in_ready` drops the cycle after S1 captures; at most 2 words are in flight.
- Release: when `out_ready` returns high, S2 reloads from S1 on that edge and `in_ready` is 1 in that same cycle, so there is no bubble.
- An input is accepted only when `in_valid` & `in_ready` at a rising edge. Inputs presented while `in_ready`=0 are ignored; the upstream stage holds them.
- Counter outputs update on the edge after the output handshake.

## Test plan
- Clean word: `palabra_rx`=8'h55, `sindrome`=4'h0 → after 2 cycles `dato`=4'hB, `tipo_error`=00, `pos_error`=0; counters unchanged.
- Single data-bit error: 8'h45, `sindrome`=4'hD → `dato`=4'hB, `tipo_error`=01, `pos_error`=4; `cnt_simple`=1 after the handshake.
- g0 error: 8'hD5, `sindrome`=4'h0 → `dato`=4'hB, `tipo_error`=01, `pos_error`=7.
- Double error: 8'h56, `sindrome`=4'h3 → `dato`=4'hB (raw), `tipo_error`=10, `pos_error`=0; `cnt_doble`=1.
- Backpressure: stream 3 words with `out_ready`=0 → `in_ready` falls after 2 accepted and outputs hold stable. Raise `out_ready` → all 3 results emerge in order, none lost or duplicated.
- Counters and reset: with `CNT_W`=2, send 5 single errors → `cnt_simple` stops at 3. Assert `clr_cnt` together with a single-error handshake → count=0. Assert `rst` with both stages full → `out_valid`=0 and `in_ready`=1 immediately, all outputs 0.

Source files
------------

// File: rtl/corrector_hamming.sv
// SECDED (8,4) correction stage: classifies each received word from its syndrome,
// repairs single errors, flags double errors and keeps saturating error counters.
module corrector_hamming #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       palabra_rx,
  input  logic [3:0]       sindrome,
  input  logic             clr_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       dato,
  output logic [1:0]       tipo_error,
  output logic [2:0]       pos_error,
  output logic [CNT_W-1:0] cnt_simple,
  output logic [CNT_W-1:0] cnt_doble
);

  typedef enum logic [1:0] {
    TIPO_NONE   = 2'b00,
    TIPO_SIMPLE = 2'b01,
    TIPO_DOBLE  = 2'b10
  } tipo_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1Valid_q;
  logic [7:0]       s1Word_q;
  logic [3:0]       s1Synd_q;

  logic             s2Valid_q;
  logic [3:0]       dato_q;
  tipo_e            tipo_q;
  logic [2:0]       pos_q;

  logic [CNT_W-1:0] cntSimple_q, cntSimple_d;
  logic [CNT_W-1:0] cntDoble_q,  cntDoble_d;

  logic             s2Load;
  logic             inAccept;
  logic             outFire;

  logic [2:0]       synd;
  logic             parityErr;
  logic [3:0]       dataRaw;
  logic [3:0]       flipMask;
  logic [3:0]       dato_d;
  tipo_e            tipo_d;
  logic [2:0]       pos_d;

  // Parity bits p0..p2 are already folded into the syndrome upstream.
  logic             unusedParityBits;
  assign unusedParityBits = ^{s1Word_q[3], s1Word_q[1], s1Word_q[0]};

  assign s2Load   = s1Valid_q & (~s2Valid_q | out_ready);
  assign in_ready = ~s1Valid_q | s2Load;
  assign inAccept = in_valid & in_ready;
  assign outFire  = s2Valid_q & out_ready;

  assign synd      = s1Synd_q[2:0];
  assign parityErr = s1Synd_q[3] ^ s1Word_q[7];
  assign dataRaw   = {s1Word_q[6], s1Word_q[5], s1Word_q[4], s1Word_q[2]};

  // A syndrome of k points at word bit k-1; only hits on data bits 6,5,4,2 touch dato.
  always_comb begin
    flipMask = 4'b0000;
    tipo_d   = TIPO_NONE;
    pos_d    = 3'd0;
    if (parityErr) begin
      tipo_d   = TIPO_SIMPLE;
      flipMask = {synd == 3'd7, synd == 3'd6, synd == 3'd5, synd == 3'd3};
      if (synd == 3'd0) begin
        pos_d = 3'd7;
      end else begin
        pos_d = synd - 3'd1;
      end
    end else if (synd != 3'd0) begin
      tipo_d = TIPO_DOBLE;
    end
    dato_d = dataRaw ^ flipMask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Word_q  <= 8'h00;
      s1Synd_q  <= 4'h0;
    end else begin
      if (inAccept) begin
        s1Word_q <= palabra_rx;
        s1Synd_q <= sindrome;
      end
      if (inAccept) begin
        s1Valid_q <= 1'b1;
      end else if (s2Load) begin
        s1Valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      dato_q    <= 4'h0;
      tipo_q    <= TIPO_NONE;
      pos_q     <= 3'd0;
    end else begin
      if (s2Load) begin
        s2Valid_q <= 1'b1;
        dato_q    <= dato_d;
        tipo_q    <= tipo_d;
        pos_q     <= pos_d;
      end else if (outFire) begin
        s2Valid_q <= 1'b0;
      end
    end
  end

  // Clear wins over a same-cycle increment; counts stick at the maximum.
  always_comb begin
    cntSimple_d = cntSimple_q;
    cntDoble_d  = cntDoble_q;
    if (clr_cnt) begin
      cntSimple_d = '0;
      cntDoble_d  = '0;
    end else if (outFire) begin
      if (tipo_q == TIPO_SIMPLE && cntSimple_q != CNT_MAX) begin
        cntSimple_d = cntSimple_q + 1'b1;
      end
      if (tipo_q == TIPO_DOBLE && cntDoble_q != CNT_MAX) begin
        cntDoble_d = cntDoble_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntSimple_q <= '0;
      cntDoble_q  <= '0;
    end else begin
      cntSimple_q <= cntSimple_d;
      cntDoble_q  <= cntDoble_d;
    end
  end

  assign out_valid  = s2Valid_q;
  assign dato       = dato_q;
  assign tipo_error = tipo_q;
  assign pos_error  = pos_q;
  assign cnt_simple = cntSimple_q;
  assign cnt_doble  = cntDoble_q;

endmodule

// File: tb/tb_corrector_hamming.sv
// Directed bench for corrector_hamming: classification vectors, backpressure,
// counter saturation/clear and asynchronous reset with a full pipeline.
module tb_corrector_hamming;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             inValid;
  logic             inReady;
  logic [7:0]       palabraRx;
  logic [3:0]       sindrome;
  logic             clrCnt;
  logic             outValid;
  logic             outReady;
  logic [3:0]       dato;
  logic [1:0]       tipoError;
  logic [2:0]       posError;
  logic [CNT_W-1:0] cntSimple;
  logic [CNT_W-1:0] cntDoble;

  int checkCount = 0;
  int failCount  = 0;

  corrector_hamming #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .palabra_rx (palabraRx),
    .sindrome   (sindrome),
    .clr_cnt    (clrCnt),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .dato       (dato),
    .tipo_error (tipoError),
    .pos_error  (posError),
    .cnt_simple (cntSimple),
    .cnt_doble  (cntDoble)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one word at a falling edge and waits (bounded) until it is accepted.
  task automatic applyStimulus(input logic [7:0] w, input logic [3:0] s);
    int guard = 0;
    @(negedge clk);
    palabraRx = w;
    sindrome  = s;
    inValid   = 1'b1;
    #1;
    while (!inReady && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!inReady) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  task automatic runWord(input string tag, input logic [7:0] w, input logic [3:0] s,
                         input logic [3:0] eDato, input logic [1:0] eTipo, input logic [2:0] ePos,
                         input bit clrAtOut, input int eSimple, input int eDoble);
    outReady = 1'b1;
    applyStimulus(w, s);
    checkOutput({tag, "_latency"}, outValid, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_valid"}, outValid, 1);
    checkOutput({tag, "_dato"}, dato, eDato);
    checkOutput({tag, "_tipo"}, tipoError, eTipo);
    checkOutput({tag, "_pos"}, posError, ePos);
    if (clrAtOut) clrCnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clrCnt = 1'b0;
    checkOutput({tag, "_drain"}, outValid, 0);
    checkOutput({tag, "_cntSimple"}, cntSimple, eSimple);
    checkOutput({tag, "_cntDoble"}, cntDoble, eDoble);
  endtask

  initial begin
    rst       = 1'b1;
    inValid   = 1'b0;
    palabraRx = 8'h00;
    sindrome  = 4'h0;
    clrCnt    = 1'b0;
    outReady  = 1'b0;
    #12;
    checkOutput("rst_outValid", outValid, 0);
    checkOutput("rst_inReady", inReady, 1);
    checkOutput("rst_dato", dato, 0);
    checkOutput("rst_tipo", tipoError, 0);
    checkOutput("rst_pos", posError, 0);
    checkOutput("rst_cntSimple", cntSimple, 0);
    checkOutput("rst_cntDoble", cntDoble, 0);
    @(negedge clk);
    rst = 1'b0;

    runWord("clean",  8'h55, 4'h0, 4'hB, 2'b00, 3'd0, 1'b0, 0, 0);
    runWord("single", 8'h45, 4'hD, 4'hB, 2'b01, 3'd4, 1'b0, 1, 0);
    runWord("g0",     8'hD5, 4'h0, 4'hB, 2'b01, 3'd7, 1'b0, 2, 0);
    runWord("double", 8'h56, 4'h3, 4'hB, 2'b10, 3'd0, 1'b0, 2, 1);
    runWord("bit6",   8'h00, 4'hF, 4'h8, 2'b01, 3'd6, 1'b0, 3, 1);

    // Backpressure: A=0x0F clean (dato 1), B=0x3C clean (dato 7), C=0x00/9 single at bit 0.
    @(negedge clk);
    outReady  = 1'b0;
    palabraRx = 8'h0F;
    sindrome  = 4'h0;
    inValid   = 1'b1;
    #1;
    checkOutput("bp_readyA", inReady, 1);
    @(negedge clk);
    palabraRx = 8'h3C;
    sindrome  = 4'h0;
    #1;
    checkOutput("bp_readyB", inReady, 1);
    @(negedge clk);
    palabraRx = 8'h00;
    sindrome  = 4'h9;
    #1;
    checkOutput("bp_readyFall", inReady, 0);
    checkOutput("bp_validA", outValid, 1);
    checkOutput("bp_datoA", dato, 4'h1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_holdReady", inReady, 0);
      checkOutput("bp_holdDato", dato, 4'h1);
      checkOutput("bp_holdTipo", tipoError, 2'b00);
    end
    outReady = 1'b1;
    #1;
    checkOutput("bp_releaseReady", inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("bp_validB", outValid, 1);
    checkOutput("bp_datoB", dato, 4'h7);
    checkOutput("bp_tipoB", tipoError, 2'b00);
    @(negedge clk);
    checkOutput("bp_validC", outValid, 1);
    checkOutput("bp_datoC", dato, 4'h0);
    checkOutput("bp_tipoC", tipoError, 2'b01);
    checkOutput("bp_posC", posError, 3'd0);
    @(negedge clk);
    checkOutput("bp_drain", outValid, 0);
    checkOutput("bp_cntSimpleSat", cntSimple, 3);

    clrCnt = 1'b1;
    @(negedge clk);
    clrCnt = 1'b0;
    checkOutput("clr_cntSimple", cntSimple, 0);
    checkOutput("clr_cntDoble", cntDoble, 0);

    for (int i = 1; i <= 5; i++) begin
      runWord("sat", 8'h45, 4'hD, 4'hB, 2'b01, 3'd4, 1'b0, (i < 3) ? i : 3, 0);
    end

    runWord("clrHandshake", 8'h45, 4'hD, 4'hB, 2'b01, 3'd4, 1'b1, 0, 0);
    runWord("double2",      8'h56, 4'h3, 4'hB, 2'b10, 3'd0, 1'b0, 0, 1);

    // Fill both stages while stalled, then reset asynchronously mid-cycle.
    outReady = 1'b0;
    applyStimulus(8'h45, 4'hD);
    applyStimulus(8'h56, 4'h3);
    #1;
    checkOutput("full_outValid", outValid, 1);
    checkOutput("full_inReady", inReady, 0);
    checkOutput("full_tipo", tipoError, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_outValid", outValid, 0);
    checkOutput("midrst_inReady", inReady, 1);
    checkOutput("midrst_dato", dato, 0);
    checkOutput("midrst_tipo", tipoError, 0);
    checkOutput("midrst_pos", posError, 0);
    checkOutput("midrst_cntSimple", cntSimple, 0);
    checkOutput("midrst_cntDoble", cntDoble, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_outValid", outValid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
